// File: rtl/uart_peer_link.sv
// Host-side UART partner: drives the core's rx line from a buffered byte stream and
// decodes the core's tx line (start, 8 data LSB first, even parity, optional stop).
module uart_peer_link #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_error,
  output logic       overrun,
  output logic [2:0] tx_state_dbg,
  output logic [2:0] rx_state_dbg
);

  // Both streams: a byte moves on a rising clock edge exactly when valid && ready are
  // both high; the producer holds data stable while valid is high and ready is low.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_SLOT   = 3'd4
  } rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_ready   = !fifo_full;
  assign push       = tx_valid && !fifo_full;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_par, tx_par_n;
  logic          tx_line_n;
  logic          tx_bit_end;

  assign tx_bit_end   = (tx_cnt == CNT_LAST);
  assign tx_state_dbg = tx_state;

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_line_n  = 1'b1;
    pop        = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_n = fifo_mem[rd_ptr[AW-1:0]];
          tx_par_n   = 1'b0;
          tx_cnt_n   = '0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        tx_line_n = 1'b0;
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_bit_n   = 3'd0;
          tx_state_n = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end
      TX_DATA: begin
        tx_line_n = tx_shift[0];
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_par_n   = tx_par ^ tx_shift[0];
          if (tx_bit == 3'd7) tx_state_n = TX_PARITY;
          else                tx_bit_n   = tx_bit + 3'd1;
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end
      TX_PARITY: begin
        tx_line_n = tx_par;
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_STOP;
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end
      TX_STOP: begin
        tx_line_n = 1'b1;
        if (tx_bit_end) begin
          tx_cnt_n = '0;
          // Chain straight into the next frame so back-to-back frames keep one stop bit.
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_shift_n = fifo_mem[rd_ptr[AW-1:0]];
            tx_par_n   = 1'b0;
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx       <= tx_line_n;
      tx_busy  <= (tx_state != TX_IDLE) || !fifo_empty;
    end
  end

  // ---------------- RX path ----------------
  logic [1:0]    rx_sync;
  logic          rx_s;
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_good;
  logic          rx_bad;
  logic          rx_sample;

  assign rx_s         = rx_sync[1];
  assign rx_sample    = (rx_cnt == CNT_LAST);
  assign rx_state_dbg = rx_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rx};
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n = '0;
          rx_bit_n = 3'd0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_PARITY;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + CNT_ONE;
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_cnt_n   = '0;
          rx_good    = ((^rx_shift) == rx_s);
          rx_bad     = ((^rx_shift) != rx_s);
          rx_state_n = RX_SLOT;
        end else begin
          rx_cnt_n = rx_cnt + CNT_ONE;
        end
      end
      RX_SLOT: begin
        // A low slot is the next frame's start bit: the core sends no stop bit.
        if (rx_sample) begin
          rx_cnt_n   = '0;
          rx_bit_n   = 3'd0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CNT_ONE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      parity_error <= rx_bad;
      overrun      <= 1'b0;
      if (rx_good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_peer_link.sv
// Directed bench for uart_peer_link: TX framing/FIFO, RX loopback, parity error,
// overrun, glitch rejection and mid-frame reset.
module tb_uart_peer_link;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_error;
  logic       overrun;
  logic [2:0] tx_state_dbg;
  logic [2:0] rx_state_dbg;

  uart_peer_link #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .parity_error (parity_error),
    .overrun      (overrun),
    .tx_state_dbg (tx_state_dbg),
    .rx_state_dbg (rx_state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int pe_cnt = 0;
  int ov_cnt = 0;
  logic [10:0] fifo_frames [10];
  int wr_acc;
  int wr_run;
  int wr_t;
  bit wr_saw_full;
  int lat;

  // Inputs change 1ns after a rising edge, so the falling edge sees settled values.
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (parity_error) pe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_byte(input string tag, input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    chk({tag, "_ready"}, tx_ready, 1);
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Edges from acceptance until tx reads 0; bounded so a stuck line still ends.
  task automatic measure_fall(output int edges);
    edges = 0;
    while (tx !== 1'b0 && edges < 40) begin
      tick(1);
      edges++;
    end
  endtask

  // Called right after the edge where tx fell; f[0] is the start bit, f[10] the stop bit.
  task automatic check_frame(input string tag, input logic [10:0] f);
    for (int i = 0; i < 11; i++) begin
      tick(1);
      chk($sformatf("%s_bit%0d_early", tag, i), tx, f[i]);
      tick(CPB - 2);
      chk($sformatf("%s_bit%0d_late", tag, i), tx, f[i]);
      chk($sformatf("%s_bit%0d_busy", tag, i), tx_busy, 1);
      tick(1);
    end
  endtask

  task automatic rx_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic par, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
    rx_bit(par);
    if (stop) rx_bit(1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    // {stop, parity, data[7:0], start} for bytes 0x00..0x09, parity worked out by hand
    fifo_frames[0] = 11'b1_0_00000000_0;
    fifo_frames[1] = 11'b1_1_00000001_0;
    fifo_frames[2] = 11'b1_1_00000010_0;
    fifo_frames[3] = 11'b1_0_00000011_0;
    fifo_frames[4] = 11'b1_1_00000100_0;
    fifo_frames[5] = 11'b1_0_00000101_0;
    fifo_frames[6] = 11'b1_0_00000110_0;
    fifo_frames[7] = 11'b1_1_00000111_0;
    fifo_frames[8] = 11'b1_1_00001000_0;
    fifo_frames[9] = 11'b1_0_00001001_0;

    // reset values, observed before any clock edge
    #1 reset = 1'b1;
    #3;
    chk("rst_tx", tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_parity_error", parity_error, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    tick(2);

    // single byte 0x41
    push_byte("single", 8'h41);
    measure_fall(lat);
    chk("single_fall_latency", lat, 2);
    check_frame("single", 11'b1_0_01000001_0);
    chk("single_busy_after", tx_busy, 0);
    chk("single_tx_idle", tx, 1);

    // ten bytes with tx_valid held high through the full FIFO
    wr_acc = 0;
    wr_run = 0;
    wr_t = 0;
    wr_saw_full = 1'b0;
    fork
      begin
        while (wr_acc < 10 && wr_t < 800) begin
          tx_data  = wr_acc[7:0];
          tx_valid = 1'b1;
          if (tx_ready) begin
            wr_acc++;
            if (!wr_saw_full) wr_run++;
          end else begin
            wr_saw_full = 1'b1;
          end
          tick(1);
          wr_t++;
        end
        tx_valid = 1'b0;
      end
      begin
        measure_fall(lat);
        chk("fifo_first_fall", tx, 0);
        for (int k = 0; k < 10; k++)
          check_frame($sformatf("fifo_%0d", k), fifo_frames[k]);
        chk("fifo_busy_after", tx_busy, 0);
      end
    join
    // the first byte leaves for the shift register one cycle after it lands,
    // so eight stored bytes take nine consecutive writes
    chk("fifo_writes_before_full", wr_run, 9);
    chk("fifo_saw_full", wr_saw_full, 1);
    chk("fifo_accepted", wr_acc, 10);

    // loopback: 0xA5 then 0x3C with no stop bit between
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    rx_frame(8'hA5, 1'b0, 1'b0);
    rx_frame(8'h3C, 1'b0, 1'b1);
    tick(4);
    check_rx("loopback");
    chk("loopback_parity_error", pe_cnt, 0);
    chk("loopback_overrun", ov_cnt, 0);

    // parity error: 0x01 needs parity 1, send 0
    rx_frame(8'h01, 1'b0, 1'b1);
    tick(4);
    chk("parerr_pulses", pe_cnt, 1);
    chk("parerr_rx_valid", rx_valid, 0);
    chk("parerr_nothing_delivered", got_q.size(), 0);
    exp_q.push_back(8'h55);
    rx_frame(8'h55, 1'b0, 1'b1);
    tick(4);
    check_rx("after_parerr");
    chk("after_parerr_pulses", pe_cnt, 1);

    // overrun: consumer stalled across two bytes
    rx_ready = 1'b0;
    rx_frame(8'h11, 1'b0, 1'b1);
    rx_frame(8'h22, 1'b0, 1'b1);
    tick(4);
    chk("overrun_pulses", ov_cnt, 1);
    chk("overrun_rx_valid", rx_valid, 1);
    chk("overrun_rx_data", rx_data, 8'h11);
    exp_q.push_back(8'h11);
    rx_ready = 1'b1;
    tick(2);
    check_rx("overrun_drain");
    chk("overrun_drained_valid", rx_valid, 0);

    // 4-cycle low glitch is a false start
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    chk("glitch_nothing_delivered", got_q.size(), 0);
    chk("glitch_parity_error", pe_cnt, 1);
    chk("glitch_overrun", ov_cnt, 1);
    chk("glitch_rx_valid", rx_valid, 0);
    chk("glitch_rx_state_idle", rx_state_dbg, 0);

    // reset while both directions are mid-DATA
    push_byte("midrst", 8'h5A);
    rx_bit(1'b0);
    rx_bit(1'b1);
    rx_bit(1'b0);
    rx_bit(1'b1);
    chk("midrst_tx_in_data", tx_state_dbg, 2);
    chk("midrst_rx_in_data", rx_state_dbg, 2);
    reset = 1'b1;
    #1;
    chk("midrst_tx_high", tx, 1);
    chk("midrst_tx_busy", tx_busy, 0);
    chk("midrst_tx_ready", tx_ready, 1);
    chk("midrst_rx_valid", rx_valid, 0);
    rx = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(200);
    chk("postrst_rx_valid", rx_valid, 0);
    chk("postrst_nothing_delivered", got_q.size(), 0);
    chk("postrst_tx_idle", tx, 1);
    chk("postrst_tx_busy", tx_busy, 0);

    push_byte("ff", 8'hFF);
    measure_fall(lat);
    chk("ff_fall_latency", lat, 2);
    check_frame("ff", 11'b1_0_11111111_0);
    chk("ff_busy_after", tx_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
